// File: rtl/char_text_writer_16x16.sv
// rtl/char_text_writer_16x16.sv - writable 16x16 character buffer with ROM-style read port
//
// Purpose: 256-cell x 7-bit character buffer. A client streams a string into
// consecutive cells starting at wr_xy; draw_char reads cells through char_xy
// with one cycle of latency, exactly like the fixed character ROMs.
// After reset the whole buffer is filled with CLEAR_CODE (256 cycles).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  request a full clear (honoured in IDLE only)
//   wr_start, wr_xy      open a write burst at cell {row,col} (IDLE only)
//   ch_valid/ch_data/ch_last/ch_ready  character stream, transfer on valid & ready
//   busy                 high while clearing or writing
//   char_xy, char_code   read address and registered read data
//
// Configuration macro: TEXT_ROW_WRAP_EN - burst pointer wraps within its row
// instead of running linearly through the whole buffer.

module char_text_writer_16x16 #(
  parameter logic [6:0] CLEAR_CODE = 7'h20,
  parameter int         MAX_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_start,
  input  logic [7:0] wr_xy,
  input  logic       ch_valid,
  input  logic [6:0] ch_data,
  input  logic       ch_last,
  output logic       ch_ready,
  output logic       busy,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE
  } state_t;

  // cnt counts transfers already taken in this burst; 9 bits so MAX_LEN=256 fits.
  localparam logic [8:0] LAST_CNT = 9'(MAX_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] clr_ptr_q, clr_ptr_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [6:0] char_code_q;

  logic       ram_we;
  logic [7:0] ram_waddr;
  logic [6:0] ram_wdata;
  logic [7:0] wr_ptr_inc;
  logic       xfer;

  logic [6:0] mem [256];

`ifdef TEXT_ROW_WRAP_EN
  // Only the column advances; the string stays on its own row.
  assign wr_ptr_inc = {wr_ptr_q[7:4], wr_ptr_q[3:0] + 4'd1};
`else
  assign wr_ptr_inc = wr_ptr_q + 8'd1;
`endif

  assign ch_ready  = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign xfer      = ch_valid & ch_ready;
  assign char_code = char_code_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = clr_ptr_q;
    ram_wdata = CLEAR_CODE;

    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 8'd1;
        if (clr_ptr_q == 8'hFF) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        // clr has priority; a simultaneous wr_start is simply dropped.
        if (clr) begin
          state_d   = S_CLEAR;
          clr_ptr_d = 8'h00;
        end else if (wr_start) begin
          state_d  = S_WRITE;
          wr_ptr_d = wr_xy;
          cnt_d    = 9'd0;
        end
      end
      S_WRITE: begin
        if (xfer) begin
          ram_we    = 1'b1;
          ram_waddr = wr_ptr_q;
          ram_wdata = ch_data;
          wr_ptr_d  = wr_ptr_inc;
          cnt_d     = cnt_q + 9'd1;
          if (ch_last || (cnt_q == LAST_CNT)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      clr_ptr_q   <= 8'h00;
      wr_ptr_q    <= 8'h00;
      cnt_q       <= 9'd0;
      char_code_q <= 7'h00;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      // Read-before-write: a same-cycle write to char_xy is seen next cycle.
      char_code_q <= mem[char_xy];
    end
  end

  // Storage is deliberately not reset; the automatic clear initialises it.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_char_text_writer_16x16.sv
// tb/tb_char_text_writer_16x16.sv - self-checking bench for char_text_writer_16x16

module tb_char_text_writer_16x16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_start = 1'b0;
  logic [7:0] wr_xy = 8'h00;
  logic       ch_valid = 1'b0;
  logic [6:0] ch_data = 7'h00;
  logic       ch_last = 1'b0;
  logic       ch_ready;
  logic       busy;
  logic [7:0] char_xy = 8'h00;
  logic [6:0] char_code;

  char_text_writer_16x16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_start (wr_start),
    .wr_xy    (wr_xy),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_last  (ch_last),
    .ch_ready (ch_ready),
    .busy     (busy),
    .char_xy  (char_xy),
    .char_code(char_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] xy;
    logic [6:0] exp;
  } vec_t;

  vec_t       tab_clear [3];
  vec_t       tab_play  [5];
  logic [6:0] model [256];
  logic [6:0] codes [32];
  logic [6:0] exp_q [$];
  int         vec_cnt = 0;
  int         miss_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] next_addr(input logic [7:0] a);
`ifdef TEXT_ROW_WRAP_EN
    next_addr = {a[7:4], a[3:0] + 4'd1};
`else
    next_addr = a + 8'd1;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 7'h20;
  endtask

  // Called at a negedge; expected value queued now, compared one clock later.
  task automatic read_check(input string name, input logic [7:0] xy, input logic [6:0] exp);
    logic [6:0] e;
    char_xy = xy;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, char_code, e);
  endtask

  // Counts negedges until busy is seen low; a blown budget is a failure.
  task automatic count_until_idle(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Opens a burst and offers n characters from codes[]; ch_last on index last_idx.
  // If ch_ready drops first, the pending character is left on the bus.
  task automatic burst(input logic [7:0] xy, input int n, input int last_idx, output int done);
    logic [7:0] a;
    a = xy;
    done = 0;
    wr_start = 1'b1;
    wr_xy = xy;
    @(negedge clk);
    wr_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ch_valid = 1'b1;
      ch_data  = codes[i];
      ch_last  = (i == last_idx);
      if (!ch_ready) break;
      @(negedge clk);
      model[a] = codes[i];
      a = next_addr(a);
      done++;
    end
    if (done == n) begin
      ch_valid = 1'b0;
      ch_last  = 1'b0;
    end
  endtask

  initial begin
    int n;
    int done;
    logic [7:0] a;
    logic seen_ready;

    tab_clear[0] = '{8'h00, 7'h20};
    tab_clear[1] = '{8'h7A, 7'h20};
    tab_clear[2] = '{8'hFF, 7'h20};
    tab_play[0]  = '{8'h23, 7'h50};
    tab_play[1]  = '{8'h24, 7'h4C};
    tab_play[2]  = '{8'h25, 7'h41};
    tab_play[3]  = '{8'h26, 7'h59};
    tab_play[4]  = '{8'h27, 7'h20};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", ch_ready, 0);
    check("rst_code", char_code, 7'h00);

    // 1: automatic clear takes 256 cycles
    rst_n = 1'b1;
    count_until_idle(400, n);
    check("clear_cycles", n, 256);
    model_clear();
    foreach (tab_clear[i]) read_check("clear_read", tab_clear[i].xy, tab_clear[i].exp);

    // 2: "PLAY" at 0x23, busy low right after the last transfer
    codes[0] = 7'h50; codes[1] = 7'h4C; codes[2] = 7'h41; codes[3] = 7'h59;
    burst(8'h23, 4, 3, done);
    check("play_done", done, 4);
    check("play_busy_fall", busy, 0);
    check("play_ready_fall", ch_ready, 0);
    foreach (tab_play[i]) read_check("play_read", tab_play[i].xy, tab_play[i].exp);

    // 3: pointer wrap from 0xFE
    codes[0] = 7'h41; codes[1] = 7'h42; codes[2] = 7'h43;
    burst(8'hFE, 3, 2, done);
    read_check("wrap_fe", 8'hFE, 7'h41);
    read_check("wrap_ff", 8'hFF, 7'h42);
`ifdef TEXT_ROW_WRAP_EN
    read_check("wrap_3rd", 8'hF0, 7'h43);
    read_check("wrap_00", 8'h00, 7'h20);
`else
    read_check("wrap_3rd", 8'h00, 7'h43);
    read_check("wrap_f0", 8'hF0, 7'h20);
`endif

    // 4: 20 characters without ch_last, only 16 accepted
    for (int i = 0; i < 20; i++) codes[i] = 7'(7'h60 + i);
    burst(8'h80, 20, -1, done);
    check("maxlen_done", done, 16);
    check("maxlen_ready", ch_ready, 0);
    check("maxlen_busy", busy, 0);
    @(negedge clk);
    check("maxlen_pending_ready", ch_ready, 0);
    ch_valid = 1'b0;
    a = 8'h80;
    for (int i = 0; i < 17; i++) begin
      read_check("maxlen_read", a, model[a]);
      a = next_addr(a);
    end

    // 5a: clr + wr_start together -> clear only
    clr = 1'b1;
    wr_start = 1'b1;
    wr_xy = 8'h00;
    @(negedge clk);
    clr = 1'b0;
    wr_start = 1'b0;
    seen_ready = ch_ready;
    n = 1;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      seen_ready = seen_ready | ch_ready;
    end
    check("clr_win_cycles", n, 257);
    check("clr_win_no_write", seen_ready, 0);
    model_clear();
    read_check("clr_win_23", 8'h23, model[8'h23]);
    read_check("clr_win_80", 8'h80, model[8'h80]);

    // 5b: clr during WRITE is ignored and not queued
    wr_start = 1'b1;
    wr_xy = 8'h50;
    @(negedge clk);
    wr_start = 1'b0;
    ch_valid = 1'b1; ch_data = 7'h31; ch_last = 1'b0;
    @(negedge clk);
    model[8'h50] = 7'h31;
    ch_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_in_write_busy", busy, 1);
    check("clr_in_write_ready", ch_ready, 1);
    ch_valid = 1'b1; ch_data = 7'h32; ch_last = 1'b1;
    @(negedge clk);
    model[8'h51] = 7'h32;
    ch_valid = 1'b0; ch_last = 1'b0;
    check("clr_in_write_end", busy, 0);
    @(negedge clk);
    check("clr_not_queued", busy, 0);
    read_check("clr_in_write_50", 8'h50, model[8'h50]);
    read_check("clr_in_write_51", 8'h51, model[8'h51]);

    // 6a: read-during-write returns old data
    wr_start = 1'b1;
    wr_xy = 8'h40;
    @(negedge clk);
    wr_start = 1'b0;
    ch_valid = 1'b1; ch_data = 7'h11; ch_last = 1'b1;
    char_xy = 8'h40;
    @(negedge clk);
    ch_valid = 1'b0; ch_last = 1'b0;
    check("rdw_old", char_code, 7'h20);
    @(negedge clk);
    check("rdw_new", char_code, 7'h11);

    // 6b: reset in the middle of a burst
    codes[0] = 7'h70; codes[1] = 7'h71;
    burst(8'h60, 2, -1, done);
    check("midrst_inburst", ch_ready, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1);
    check("midrst_ready", ch_ready, 0);
    check("midrst_code", char_code, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    count_until_idle(400, n);
    check("midrst_clear_cycles", n, 256);
    model_clear();
    read_check("midrst_60", 8'h60, model[8'h60]);
    read_check("midrst_61", 8'h61, model[8'h61]);
    read_check("midrst_40", 8'h40, model[8'h40]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
